// File: rtl/ps2_mouse_packet_rx_pkg.sv
// Shared definitions for the PS/2 mouse receiver: frame field counts,
// byte0 bit positions, frame FSM states and the odd-parity helper.
package ps2_mouse_packet_rx_pkg;

    localparam int DATA_BITS = 8;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_rx_clk_filter.sv
// ps2_clk synchroniser and glitch filter; emits a one-cycle registered strobe
// when the filtered clock falls.
module ps2_mouse_packet_rx_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_fall_stb
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // The idle bus is high, so the filtered level starts high and no fall is seen at startup.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta     <= 1'b1;
            r_sync     <= 1'b1;
            r_level    <= 1'b1;
            r_cnt      <= '0;
            o_fall_stb <= 1'b0;
        end else begin
            r_meta     <= i_raw;
            r_sync     <= r_meta;
            o_fall_stb <= 1'b0;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_level    <= r_sync;
                r_cnt      <= '0;
                o_fall_stb <= ~r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// Receive-only PS/2 mouse front end: frame deserialiser with timeout,
// 3-byte stream packet assembler and held button/movement outputs.
module ps2_mouse_packet_rx
    import ps2_mouse_packet_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clock,
    input  logic       globalReset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left_btn,
    output logic       right_btn,
    output logic       middle_btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       packet_valid,
    output logic       frame_error,
    output logic [1:0] dbg_state
);

    localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    logic                 w_fall;
    logic                 r_data_meta;
    logic                 r_data_sync;
    frame_state_t         r_state;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [TO_W-1:0]      r_to_cnt;
    logic [1:0]           r_byte_idx;
    logic [2:0]           r_btn;
    logic                 r_xs;
    logic                 r_ys;
    logic                 r_xo;
    logic                 r_yo;
    logic [DATA_BITS-1:0] r_byte1;

    ps2_mouse_packet_rx_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .i_clk      (clock),
        .i_rst      (globalReset),
        .i_raw      (ps2_clk),
        .o_fall_stb (w_fall)
    );

    always_ff @(posedge clock) begin
        if (globalReset) begin
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    assign dbg_state = r_state;

    always_ff @(posedge clock) begin
        if (globalReset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_idx   <= '0;
            r_btn        <= '0;
            r_xs         <= 1'b0;
            r_ys         <= 1'b0;
            r_xo         <= 1'b0;
            r_yo         <= 1'b0;
            r_byte1      <= '0;
            left_btn     <= 1'b0;
            right_btn    <= 1'b0;
            middle_btn   <= 1'b0;
            dx           <= '0;
            dy           <= '0;
            x_ovf        <= 1'b0;
            y_ovf        <= 1'b0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_data_sync) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {r_data_sync, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_parity <= r_data_sync;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (r_data_sync && parity_ok(r_shift, r_parity)) begin
                            case (r_byte_idx)
                                2'd1: begin
                                    r_byte1    <= r_shift;
                                    r_byte_idx <= 2'd2;
                                end
                                2'd2: begin
                                    r_byte_idx   <= 2'd0;
                                    left_btn     <= r_btn[BTN_L];
                                    right_btn    <= r_btn[BTN_R];
                                    middle_btn   <= r_btn[BTN_M];
                                    dx           <= {r_xs, r_byte1};
                                    dy           <= {r_ys, r_shift};
                                    x_ovf        <= r_xo;
                                    y_ovf        <= r_yo;
                                    packet_valid <= 1'b1;
                                end
                                default: begin
                                    // Header byte must carry the sync bit; otherwise we stay unaligned.
                                    if (r_shift[SYNC]) begin
                                        r_btn      <= r_shift[BTN_M:BTN_L];
                                        r_xs       <= r_shift[XS];
                                        r_ys       <= r_shift[YS];
                                        r_xo       <= r_shift[XO];
                                        r_yo       <= r_shift[YO];
                                        r_byte_idx <= 2'd1;
                                    end else begin
                                        r_byte_idx <= 2'd0;
                                    end
                                end
                            endcase
                        end else begin
                            r_byte_idx  <= 2'd0;
                            frame_error <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state != ST_IDLE) begin
                if (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                    r_state     <= ST_IDLE;
                    r_byte_idx  <= 2'd0;
                    r_to_cnt    <= '0;
                    frame_error <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Directed bench for ps2_mouse_packet_rx: PS/2 frame driver, expected-event
// queue filled by stimulus, and an independent monitor that pops on each strobe.
`timescale 1ns/1ps
module tb_ps2_mouse_packet_rx;

    localparam int HALF_BIT = 30;   // 30 us at a 1 MHz system clock
    localparam int GLITCH   = 7;    // FILTER_LEN-1 samples

    logic       clock = 1'b0;
    logic       globalReset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       left_btn, right_btn, middle_btn;
    logic [8:0] dx, dy;
    logic       x_ovf, y_ovf;
    logic       packet_valid, frame_error;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected event: bit 23 = 1 packet / 0 frame error, bits 22:0 = output fields.
    logic [23:0] exp_q[$];
    logic [22:0] last_out = '0;
    logic [22:0] w_act;

    assign w_act = {left_btn, right_btn, middle_btn, dx, dy, x_ovf, y_ovf};

    ps2_mouse_packet_rx #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (2000),
        .FILTER_LEN (8)
    ) dut (
        .clock        (clock),
        .globalReset  (globalReset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .left_btn     (left_btn),
        .right_btn    (right_btn),
        .middle_btn   (middle_btn),
        .dx           (dx),
        .dy           (dy),
        .x_ovf        (x_ovf),
        .y_ovf        (y_ovf),
        .packet_valid (packet_valid),
        .frame_error  (frame_error),
        .dbg_state    (dbg_state)
    );

    always #500 clock = ~clock;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [23:0] mk_pkt(input logic l, input logic r, input logic m,
                                           input logic [8:0] ex, input logic [8:0] ey,
                                           input logic xo, input logic yo);
        return {1'b1, l, r, m, ex, ey, xo, yo};
    endfunction

    // One device-to-host bit: data set while clock high, sampled on the falling edge.
    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(GLITCH);
            ps2_clk = 1'b1;
            wait_cyc(HALF_BIT - 10 - GLITCH);
        end else begin
            wait_cyc(HALF_BIT);
        end
        ps2_clk = 1'b0;
        wait_cyc(HALF_BIT);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input int glitch_bit);
        logic [10:0] f;
        logic        par;
        par = ~(^b) ^ bad_par;
        f = {1'b1, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], (i == glitch_bit));
        ps2_data = 1'b1;
        wait_cyc(100);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int glitch_bit);
        send_frame(b0, 1'b0, 11, glitch_bit);
        send_frame(b1, 1'b0, 11, -1);
        send_frame(b2, 1'b0, 11, -1);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({w_act, packet_valid, frame_error, dbg_state} != '0) begin
            failures++;
            $display("FAIL %s got outs=%h pv=%0b fe=%0b st=%0d expected all zero",
                     name, w_act, packet_valid, frame_error, dbg_state);
        end
    endtask

    always @(negedge clock) begin
        logic [23:0] e;
        if (globalReset) begin
            last_out = '0;
        end else if (packet_valid || frame_error) begin
            checks++;
            if (packet_valid && frame_error) begin
                failures++;
                $display("FAIL strobe_overlap got pv=1 fe=1 expected at most one");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got pv=%0b fe=%0b expected none", packet_valid, frame_error);
            end else begin
                e = exp_q.pop_front();
                if (e[23] != packet_valid) begin
                    failures++;
                    $display("FAIL event_kind got pv=%0b expected pv=%0b", packet_valid, e[23]);
                end else if (packet_valid) begin
                    if (w_act != e[22:0]) begin
                        failures++;
                        $display("FAIL packet got %h expected %h", w_act, e[22:0]);
                    end
                    last_out = e[22:0];
                end else if (w_act != last_out) begin
                    failures++;
                    $display("FAIL hold_on_error got %h expected %h", w_act, last_out);
                end
            end
        end
    end

    initial begin
        globalReset = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        wait_cyc(10);
        check_idle_outputs("reset_initial");
        globalReset = 1'b0;
        wait_cyc(20);

        // Reset mid-frame after start bit plus 4 data bits of a header byte.
        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1, 1'b0);
        globalReset = 1'b1;
        wait_cyc(3);
        check_idle_outputs("reset_mid_frame");
        globalReset = 1'b0;
        wait_cyc(5);
        check_idle_outputs("after_reset");
        exp_q.push_back(mk_pkt(1'b1, 1'b0, 1'b0, 9'h07F, 9'h080, 1'b0, 1'b0));
        send_packet(8'h09, 8'h7F, 8'h80, -1);

        exp_q.push_back(mk_pkt(1'b1, 1'b0, 1'b0, 9'h005, 9'h1FB, 1'b0, 1'b0));
        send_packet(8'h29, 8'h05, 8'hFB, -1);

        // Bad parity on byte1 drops the partial packet.
        exp_q.push_back(24'h0);
        send_frame(8'h09, 1'b0, 11, -1);
        send_frame(8'h33, 1'b1, 11, -1);
        exp_q.push_back(mk_pkt(1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0));
        send_packet(8'h0A, 8'h00, 8'h00, -1);

        // Header without sync bit is ignored silently.
        send_frame(8'h00, 1'b0, 11, -1);
        exp_q.push_back(mk_pkt(1'b0, 1'b0, 1'b1, 9'h0FF, 9'h001, 1'b0, 1'b0));
        send_packet(8'h0C, 8'hFF, 8'h01, -1);

        // Clock stalls high after 5 bits: exactly one timeout error.
        exp_q.push_back(24'h0);
        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1, 1'b0);
        wait_cyc(3000);
        exp_q.push_back(mk_pkt(1'b1, 1'b1, 1'b0, 9'h002, 9'h0FE, 1'b0, 1'b0));
        send_packet(8'h0B, 8'h02, 8'hFE, -1);

        // Short low glitch inside a bit's high phase must not add a bit.
        exp_q.push_back(mk_pkt(1'b0, 1'b0, 1'b0, 9'h010, 9'h020, 1'b0, 1'b0));
        send_packet(8'h08, 8'h10, 8'h20, 3);

        // Sign and overflow bits.
        exp_q.push_back(mk_pkt(1'b0, 1'b0, 1'b0, 9'h180, 9'h001, 1'b1, 1'b1));
        send_packet(8'hD8, 8'h80, 8'h01, -1);

        wait_cyc(200);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got %0d outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
